sprite_palette_bank: RTL

Parametrised, runtime-writable colour palette for sprite rendering. It replaces fixed per-sprite palette ROMs with a multi-bank register-file palette. The palette is loaded through a write port, selected per frame with a double-buffered bank switch, and read through a 2-stage pipelined lookup that flags the transparent index. It sits between the sprite pixel-index fetch and the colour mapper, in the VGA pixel clock domain.

---
 rtl/sprite_palette_bank_if.sv | 49 ++++
 rtl/sprite_palette_bank.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sprite_palette_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_palette_bank_if
//  Purpose  : Bundles the pixel lookup, bank switch, palette write and
//             colour output signals of sprite_palette_bank.
//  Revision : 1.0  initial release
// ============================================================================
interface sprite_palette_bank_if #(
  parameter int IDX_W = 4,
  parameter int CH_W  = 4,
  parameter int BANKS = 2
);
  localparam int c_bank_w = (BANKS > 1) ? $clog2(BANKS) : 1;

  // Lookup request
  logic                  pix_valid_i;
  logic [IDX_W-1:0]      pix_index_i;
  // Bank selection
  logic                  frame_start;
  logic                  bank_req_valid;
  logic [c_bank_w-1:0]   bank_req;
  // Palette write port
  logic                  wr_en;
  logic [c_bank_w-1:0]   wr_bank;
  logic [IDX_W-1:0]      wr_index;
  logic [3*CH_W-1:0]     wr_data;
  // Lookup result
  logic                  pix_valid_o;
  logic [CH_W-1:0]       red;
  logic [CH_W-1:0]       green;
  logic [CH_W-1:0]       blue;
  logic                  transparent_o;
  logic [c_bank_w-1:0]   active_bank_o;

  // Pixel fetch / CPU side drives requests and writes
  modport master (
    output pix_valid_i, pix_index_i, frame_start, bank_req_valid, bank_req,
           wr_en, wr_bank, wr_index, wr_data,
    input  pix_valid_o, red, green, blue, transparent_o, active_bank_o
  );

  // Palette side answers with colours
  modport slave (
    input  pix_valid_i, pix_index_i, frame_start, bank_req_valid, bank_req,
           wr_en, wr_bank, wr_index, wr_data,
    output pix_valid_o, red, green, blue, transparent_o, active_bank_o
  );
endinterface
`default_nettype wire

// File: rtl/sprite_palette_bank.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_palette_bank
//  Purpose  : Multi-bank runtime-writable sprite palette. Bank switches are
//             double-buffered on frame_start; lookups run through a 2-stage
//             pipeline with write-first bypass and a transparent-index flag.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_palette_bank #(
  parameter int IDX_W           = 4,
  parameter int CH_W            = 4,
  parameter int BANKS           = 2,
  parameter int TRANSPARENT_IDX = 0
) (
  input  wire logic             Clk,
  input  wire logic             Reset_n,
  sprite_palette_bank_if.slave  bus
);
  localparam int c_bank_w  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int c_entries = 2**IDX_W;
  localparam int c_dw      = 3*CH_W;
  // Storage is laid out over the full power-of-two bank space so that any
  // {bank, index} address is a legal slice; unused banks read as zero.
  localparam int c_slots   = (2**c_bank_w) * c_entries;
  localparam logic [c_bank_w:0]  c_banks      = (c_bank_w+1)'(BANKS);
  localparam logic [IDX_W-1:0]   c_transp_idx = IDX_W'(TRANSPARENT_IDX);

  logic                   w_wr_ok;
  logic                   w_req_ok;
  logic [c_slots*c_dw-1:0] w_mem;
  logic [c_bank_w+IDX_W-1:0] w_slot;
  logic [c_dw-1:0]        w_stored;
  logic                   w_hit;
  logic [c_dw-1:0]        w_rd_color;

  logic [c_bank_w-1:0]    r_active;
  logic [c_bank_w-1:0]    r_pend_bank;
  logic                   r_pend;

  logic                   r_s1_valid;
  logic [IDX_W-1:0]       r_s1_index;
  logic [c_bank_w-1:0]    r_s1_bank;

  logic                   r_s2_valid;
  logic [c_dw-1:0]        r_s2_color;
  logic                   r_s2_transp;

  // Out-of-range banks are filtered here so nothing downstream sees them
  assign w_wr_ok  = bus.wr_en          && ({1'b0, bus.wr_bank}  < c_banks);
  assign w_req_ok = bus.bank_req_valid && ({1'b0, bus.bank_req} < c_banks);

  // Bank selection: requests park in pending until a frame boundary commits
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_active    <= '0;
      r_pend_bank <= '0;
      r_pend      <= 1'b0;
    end else if (bus.frame_start) begin
      if (w_req_ok) begin
        r_active    <= bus.bank_req;
        r_pend_bank <= bus.bank_req;
        r_pend      <= 1'b0;
      end else if (r_pend) begin
        r_active    <= r_pend_bank;
        r_pend      <= 1'b0;
      end
    end else if (w_req_ok) begin
      r_pend_bank <= bus.bank_req;
      r_pend      <= 1'b1;
    end
  end

  // Palette storage: one flop word per entry of every implemented bank
  for (genvar b = 0; b < 2**c_bank_w; b++) begin : g_bank
    if (b < BANKS) begin : g_live
      for (genvar e = 0; e < c_entries; e++) begin : g_entry
        logic [c_dw-1:0] r_entry;

        // Entry write when the decoded bank/index matches
        always_ff @(posedge Clk) begin
          if (!Reset_n) begin
            r_entry <= '0;
          end else if (w_wr_ok && (bus.wr_bank == c_bank_w'(b))
                               && (bus.wr_index == IDX_W'(e))) begin
            r_entry <= bus.wr_data;
          end
        end

        assign w_mem[(b*c_entries+e)*c_dw +: c_dw] = r_entry;
      end
    end else begin : g_pad
      assign w_mem[b*c_entries*c_dw +: c_entries*c_dw] = '0;
    end
  end

  // S2 read with write-first bypass so a same-cycle write is seen at once
  assign w_slot     = {r_s1_bank, r_s1_index};
  assign w_stored   = w_mem[w_slot*c_dw +: c_dw];
  assign w_hit      = w_wr_ok && (bus.wr_bank == r_s1_bank)
                              && (bus.wr_index == r_s1_index);
  assign w_rd_color = w_hit ? bus.wr_data : w_stored;

  // Free-running lookup pipeline; bank is latched with the pixel at S1
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_index  <= '0;
      r_s1_bank   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_color  <= '0;
      r_s2_transp <= 1'b0;
    end else begin
      r_s1_valid  <= bus.pix_valid_i;
      r_s1_index  <= bus.pix_index_i;
      r_s1_bank   <= r_active;
      r_s2_valid  <= r_s1_valid;
      r_s2_color  <= r_s1_valid ? w_rd_color : '0;
      r_s2_transp <= r_s1_valid && (r_s1_index == c_transp_idx);
    end
  end

  assign bus.pix_valid_o   = r_s2_valid;
  assign bus.red           = r_s2_color[3*CH_W-1 -: CH_W];
  assign bus.green         = r_s2_color[2*CH_W-1 -: CH_W];
  assign bus.blue          = r_s2_color[CH_W-1:0];
  assign bus.transparent_o = r_s2_transp;
  assign bus.active_bank_o = r_active;

endmodule
`default_nettype wire
